// File: rtl/display_scan_mux.sv
// display_scan_mux
//   Time-multiplexed scanner for a DIGITS-wide common-anode 7-segment display.
//   A frame holds DIGITS hex nibbles and decimal points. One digit is driven per
//   slot of PRESCALE cycles. Each slot starts with BLANK_CYCLES cycles of all
//   enables off, which prevents ghosting between digits. Data loaded during a
//   frame is held in a pending buffer. It is committed only at the frame boundary.
//
// Ports
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   data_in     : DIGITS nibbles; digit i = data_in[4i+3:4i]
//   dp_in       : decimal point per digit, active-high
//   load        : one-cycle strobe capturing data_in/dp_in
//   lz_blank    : leading-zero blanking enable (level)
//   nibble      : value of the current digit, to the 7-segment decoder
//   dp          : decimal point of the current digit
//   digit_en_n  : active-low digit enables (one-hot-low or all ones)
//   frame_start : first cycle of digit 0's slot
//   load_ack    : one-cycle pulse after buffered data is committed
module display_scan_mux #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lz_blank,
  output logic [3:0]            nibble,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_en_n,
  output logic                  frame_start,
  output logic                  load_ack
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);

  logic [PW-1:0]         presc;
  logic [DW-1:0]         digit;
  logic [4*DIGITS-1:0]   disp_data;
  logic [DIGITS-1:0]     disp_dp;
  logic [4*DIGITS-1:0]   pend_data;
  logic [DIGITS-1:0]     pend_dp;
  logic                  pend_valid;
  // Registered copy of rst_n. It holds the counters on the first edge out of
  // reset, so cycle 0 starts with presc = 0. It also gates frame_start and the
  // digit enables.
  logic                  run;

  logic                  frame_end;
  logic                  in_blank;
  logic                  suppress;

  assign frame_end = (presc == PRESC_LAST) && (digit == DIGIT_LAST);

  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign in_blank = 1'b0;
  end else begin : g_blank
    localparam logic [PW-1:0] BLANK_L = PW'(BLANK_CYCLES);
    assign in_blank = (presc < BLANK_L);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc      <= '0;
      digit      <= '0;
      disp_data  <= '0;
      disp_dp    <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      load_ack   <= 1'b0;
      run        <= 1'b0;
    end else begin
      run      <= 1'b1;
      load_ack <= 1'b0;
      if (run) begin
        if (presc == PRESC_LAST) begin
          presc <= '0;
          digit <= (digit == DIGIT_LAST) ? '0 : digit + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
      // A load on the boundary edge bypasses the pending buffer.
      if (run && frame_end && (pend_valid || load)) begin
        disp_data  <= load ? data_in : pend_data;
        disp_dp    <= load ? dp_in   : pend_dp;
        pend_valid <= 1'b0;
        load_ack   <= 1'b1;
      end else if (load) begin
        pend_data  <= data_in;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end
    end
  end

  // Select the current digit. A digit other than digit 0 is suppressed when it
  // and every more-significant digit are zero.
  always_comb begin
    nibble   = '0;
    dp       = 1'b0;
    suppress = lz_blank && (digit != '0);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (digit == DW'(i)) begin
        nibble = disp_data[4*i +: 4];
        dp     = disp_dp[i];
      end
      if ((DW'(i) >= digit) && (disp_data[4*i +: 4] != 4'h0)) begin
        suppress = 1'b0;
      end
    end
  end

  always_comb begin
    digit_en_n = '1;
    if (run && !in_blank && !suppress) begin
      digit_en_n[digit] = 1'b0;
    end
  end

  assign frame_start = run && (presc == '0) && (digit == '0);

endmodule

// File: tb/tb_display_scan_mux.sv
module tb_display_scan_mux;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        lz_blank;
  logic [3:0]  nibble;
  logic        dp;
  logic [3:0]  digit_en_n;
  logic        frame_start;
  logic        load_ack;

  int n_vec;
  int n_fail;
  int cyc;

  display_scan_mux #(
    .DIGITS      (4),
    .PRESCALE    (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .load       (load),
    .lz_blank   (lz_blank),
    .nibble     (nibble),
    .dp         (dp),
    .digit_en_n (digit_en_n),
    .frame_start(frame_start),
    .load_ack   (load_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        ld;
    logic [15:0] d;
    logic [3:0]  dpi;
    logic        lz;
    logic [3:0]  nib;
    logic        dpo;
    logic [3:0]  en;
    logic        fs;
    logic        ack;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int c, input logic ld, input logic [15:0] d,
                     input logic [3:0] dpi, input logic lz, input logic [3:0] nib,
                     input logic dpo, input logic [3:0] en, input logic fs,
                     input logic ack);
    vec_t v;
    v.cyc = c; v.ld = ld; v.d = d; v.dpi = dpi; v.lz = lz;
    v.nib = nib; v.dpo = dpo; v.en = en; v.fs = fs; v.ack = ack;
    vecs.push_back(v);
  endtask

  task automatic check_all(input string name, input logic [3:0] nib,
                           input logic dpo, input logic [3:0] en,
                           input logic fs, input logic ack);
    n_vec++;
    if (nibble !== nib || dp !== dpo || digit_en_n !== en ||
        frame_start !== fs || load_ack !== ack) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got nibble=%h dp=%b en=%b fs=%b ack=%b, want nibble=%h dp=%b en=%b fs=%b ack=%b",
               name, cyc, nibble, dp, digit_en_n, frame_start, load_ack,
               nib, dpo, en, fs, ack);
    end
  endtask

  // One step = move to the middle of the next cycle. load is a single-cycle strobe.
  task automatic advance();
    @(negedge clk);
    cyc++;
    load = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load = 1'b0;
    lz_blank = 1'b0;
    data_in = '0;
    dp_in = '0;
    repeat (3) @(negedge clk);
    check_all("in_reset", 4'h0, 1'b0, 4'b1111, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc = -1;
  endtask

  initial begin
    n_vec = 0;
    n_fail = 0;
    cyc = -1;

    //   cyc  ld  data     dpi     lz   nib   dp   en       fs   ack
    // Frame 0: empty display, load 1234 at cycle 5
    add(0,   0, 16'h0,    4'b0000, 0, 4'h0, 0, 4'b1111, 1, 0);
    add(1,   0, 16'h0,    4'b0000, 0, 4'h0, 0, 4'b1111, 0, 0);
    add(2,   0, 16'h0,    4'b0000, 0, 4'h0, 0, 4'b1110, 0, 0);
    add(5,   1, 16'h1234, 4'b0010, 0, 4'h0, 0, 4'b1110, 0, 0);
    add(7,   0, 16'h0,    4'b0000, 0, 4'h0, 0, 4'b1110, 0, 0);
    add(8,   0, 16'h0,    4'b0000, 0, 4'h0, 0, 4'b1111, 0, 0);
    add(10,  0, 16'h0,    4'b0000, 0, 4'h0, 0, 4'b1101, 0, 0);
    add(15,  0, 16'h0,    4'b0000, 0, 4'h0, 0, 4'b1101, 0, 0);
    add(26,  0, 16'h0,    4'b0000, 0, 4'h0, 0, 4'b0111, 0, 0);
    add(31,  0, 16'h0,    4'b0000, 0, 4'h0, 0, 4'b0111, 0, 0);
    // Frame 1: shows 1234, dp on digit 1
    add(32,  0, 16'h0,    4'b0000, 0, 4'h4, 0, 4'b1111, 1, 1);
    add(33,  0, 16'h0,    4'b0000, 0, 4'h4, 0, 4'b1111, 0, 0);
    add(34,  0, 16'h0,    4'b0000, 0, 4'h4, 0, 4'b1110, 0, 0);
    add(39,  0, 16'h0,    4'b0000, 0, 4'h4, 0, 4'b1110, 0, 0);
    add(42,  0, 16'h0,    4'b0000, 0, 4'h3, 1, 4'b1101, 0, 0);
    add(47,  0, 16'h0,    4'b0000, 0, 4'h3, 1, 4'b1101, 0, 0);
    add(50,  0, 16'h0,    4'b0000, 0, 4'h2, 0, 4'b1011, 0, 0);
    add(58,  0, 16'h0,    4'b0000, 0, 4'h1, 0, 4'b0111, 0, 0);
    add(63,  0, 16'h0,    4'b0000, 0, 4'h1, 0, 4'b0111, 0, 0);
    // Frame 2: no ack, two loads (latest wins)
    add(64,  0, 16'h0,    4'b0000, 0, 4'h4, 0, 4'b1111, 1, 0);
    add(67,  1, 16'h1111, 4'b0000, 0, 4'h4, 0, 4'b1110, 0, 0);
    add(84,  1, 16'hABCD, 4'b0000, 0, 4'h2, 0, 4'b1011, 0, 0);
    add(95,  0, 16'h0,    4'b0000, 0, 4'h1, 0, 4'b0111, 0, 0);
    // Frame 3: ABCD, load 00F0 in the last cycle
    add(96,  0, 16'h0,    4'b0000, 0, 4'hD, 0, 4'b1111, 1, 1);
    add(97,  0, 16'h0,    4'b0000, 0, 4'hD, 0, 4'b1111, 0, 0);
    add(98,  0, 16'h0,    4'b0000, 0, 4'hD, 0, 4'b1110, 0, 0);
    add(106, 0, 16'h0,    4'b0000, 0, 4'hC, 0, 4'b1101, 0, 0);
    add(114, 0, 16'h0,    4'b0000, 0, 4'hB, 0, 4'b1011, 0, 0);
    add(122, 0, 16'h0,    4'b0000, 0, 4'hA, 0, 4'b0111, 0, 0);
    add(127, 1, 16'h00F0, 4'b0000, 0, 4'hA, 0, 4'b0111, 0, 0);
    // Frame 4: 00F0 committed immediately; lz on from 140, load 0050
    add(128, 0, 16'h0,    4'b0000, 0, 4'h0, 0, 4'b1111, 1, 1);
    add(130, 0, 16'h0,    4'b0000, 0, 4'h0, 0, 4'b1110, 0, 0);
    add(136, 0, 16'h0,    4'b0000, 0, 4'hF, 0, 4'b1111, 0, 0);
    add(138, 0, 16'h0,    4'b0000, 0, 4'hF, 0, 4'b1101, 0, 0);
    add(140, 0, 16'h0,    4'b0000, 1, 4'hF, 0, 4'b1101, 0, 0);
    add(146, 0, 16'h0,    4'b0000, 1, 4'h0, 0, 4'b1111, 0, 0);
    add(150, 1, 16'h0050, 4'b0000, 1, 4'h0, 0, 4'b1111, 0, 0);
    // Frame 5: 0050 with lz: digits 3,2 suppressed
    add(160, 0, 16'h0,    4'b0000, 1, 4'h0, 0, 4'b1111, 1, 1);
    add(162, 0, 16'h0,    4'b0000, 1, 4'h0, 0, 4'b1110, 0, 0);
    add(170, 0, 16'h0,    4'b0000, 1, 4'h5, 0, 4'b1101, 0, 0);
    add(178, 0, 16'h0,    4'b0000, 1, 4'h0, 0, 4'b1111, 0, 0);
    add(183, 0, 16'h0,    4'b0000, 1, 4'h0, 0, 4'b1111, 0, 0);
    add(186, 0, 16'h0,    4'b0000, 1, 4'h0, 0, 4'b1111, 0, 0);
    add(191, 1, 16'h0000, 4'b0000, 1, 4'h0, 0, 4'b1111, 0, 0);
    // Frame 6: all zero with lz: only digit 0 driven; lz dropped at 220
    add(192, 0, 16'h0,    4'b0000, 1, 4'h0, 0, 4'b1111, 1, 1);
    add(194, 0, 16'h0,    4'b0000, 1, 4'h0, 0, 4'b1110, 0, 0);
    add(202, 0, 16'h0,    4'b0000, 1, 4'h0, 0, 4'b1111, 0, 0);
    add(210, 0, 16'h0,    4'b0000, 1, 4'h0, 0, 4'b1111, 0, 0);
    add(220, 0, 16'h0,    4'b0000, 0, 4'h0, 0, 4'b1111, 0, 0);
    add(222, 0, 16'h0,    4'b0000, 0, 4'h0, 0, 4'b0111, 0, 0);
    add(224, 0, 16'h0,    4'b0000, 0, 4'h0, 0, 4'b1111, 1, 0);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      while (cyc < vecs[i].cyc) advance();
      check_all("vec", vecs[i].nib, vecs[i].dpo, vecs[i].en, vecs[i].fs, vecs[i].ack);
      if (vecs[i].ld) begin
        load = 1'b1;
        data_in = vecs[i].d;
        dp_in = vecs[i].dpi;
      end
      lz_blank = vecs[i].lz;
    end

    // Reset in the middle of a frame that holds pending data
    do_reset();
    while (cyc < 40) advance();
    load = 1'b1;
    data_in = 16'h9876;
    dp_in = 4'b1111;
    while (cyc < 45) advance();
    rst_n = 1'b0;
    advance();
    check_all("mid_reset", 4'h0, 1'b0, 4'b1111, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc = -1;
    advance();
    check_all("restart_c0", 4'h0, 1'b0, 4'b1111, 1'b1, 1'b0);
    while (cyc < 2) advance();
    check_all("restart_c2", 4'h0, 1'b0, 4'b1110, 1'b0, 1'b0);
    while (cyc < 32) advance();
    check_all("restart_noack", 4'h0, 1'b0, 4'b1111, 1'b1, 1'b0);
    while (cyc < 58) advance();
    check_all("restart_d3", 4'h0, 1'b0, 4'b0111, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
